// File: rtl/rdft_bin_engine.sv
// Sliding DFT engine: an N-deep comb delay line feeding NBINS time-multiplexed
// recursive bins, S_k <= W_k * (S_k + x[n] - x[n-N]), one sample per NBINS+2 cycles.
module rdft_bin_engine #(
    parameter int DW    = 16,
    parameter int N     = 53,
    parameter int NBINS = 4,
    parameter int TW    = 18,
    parameter int ACCW  = DW + $clog2(N) + 2,
    localparam int BW   = (NBINS > 1) ? $clog2(NBINS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [DW-1:0]   in_re,
    input  logic signed [DW-1:0]   in_im,
    input  logic                   tw_we,
    input  logic [BW-1:0]          tw_addr,
    input  logic signed [TW-1:0]   tw_cos,
    input  logic signed [TW-1:0]   tw_sin,
    output logic                   out_valid,
    output logic [BW-1:0]          out_bin,
    output logic signed [ACCW-1:0] out_re,
    output logic signed [ACCW-1:0] out_im,
    output logic                   out_primed
);

    // state  | meaning
    // S_IDLE | waiting for a sample; twiddle writes accepted here only
    // S_COMB | comb stage: diff = x - x[n-N], delay line write, fill update
    // S_BIN  | rotate and accumulate bin cur_bin, emit its result
    typedef enum logic [1:0] {S_IDLE, S_COMB, S_BIN} state_t;

    localparam int PTRW = $clog2(N);
    localparam int FW   = $clog2(N + 1);
    localparam int PW   = ACCW + TW + 2;

    localparam logic signed [TW-1:0] TW_ONE   = {2'b01, {(TW-2){1'b0}}};
    localparam logic [FW-1:0]        FILL_N   = FW'(N);
    localparam logic [PTRW-1:0]      PTR_LAST = PTRW'(N - 1);
    localparam logic [BW-1:0]        LAST_BIN = BW'(NBINS - 1);
    localparam logic signed [PW-1:0] RND      = {{(PW-TW+2){1'b0}}, 1'b1, {(TW-3){1'b0}}};
    localparam logic signed [PW-1:0] SAT_MAX  = {{(PW-ACCW+1){1'b0}}, {(ACCW-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN  = {{(PW-ACCW+1){1'b1}}, {(ACCW-1){1'b0}}};

    state_t                 state;
    logic [BW-1:0]          cur_bin;
    logic [FW-1:0]          fill;
    logic [PTRW-1:0]        wr_ptr;
    logic signed [DW-1:0]   x_re, x_im;
    logic signed [DW:0]     diff_re, diff_im;
    logic signed [ACCW-1:0] acc_re [NBINS];
    logic signed [ACCW-1:0] acc_im [NBINS];
    logic signed [TW-1:0]   tw_c   [NBINS];
    logic signed [TW-1:0]   tw_s   [NBINS];
    logic signed [DW-1:0]   dly_re [N];
    logic signed [DW-1:0]   dly_im [N];

    logic                   tw_addr_ok;
    logic signed [DW-1:0]   old_re, old_im;
    logic signed [ACCW:0]   s_re, s_im;
    logic signed [PW-1:0]   s_re_x, s_im_x, c_x, sn_x, p_re, p_im, q_re, q_im;
    logic signed [ACCW-1:0] sat_re, sat_im;

    assign tw_addr_ok = ({{(32-BW){1'b0}}, tw_addr} < 32'(NBINS));

    // Slots not yet written since reset read as zero, so the RAM needs no clear.
    always_comb begin
        old_re = '0;
        old_im = '0;
        if (fill == FILL_N) begin
            old_re = dly_re[wr_ptr];
            old_im = dly_im[wr_ptr];
        end
    end

    always_comb begin
        s_re   = {acc_re[cur_bin][ACCW-1], acc_re[cur_bin]} + {{(ACCW-DW){diff_re[DW]}}, diff_re};
        s_im   = {acc_im[cur_bin][ACCW-1], acc_im[cur_bin]} + {{(ACCW-DW){diff_im[DW]}}, diff_im};
        s_re_x = {{(PW-ACCW-1){s_re[ACCW]}}, s_re};
        s_im_x = {{(PW-ACCW-1){s_im[ACCW]}}, s_im};
        c_x    = {{(PW-TW){tw_c[cur_bin][TW-1]}}, tw_c[cur_bin]};
        sn_x   = {{(PW-TW){tw_s[cur_bin][TW-1]}}, tw_s[cur_bin]};
        p_re   = s_re_x * c_x - s_im_x * sn_x;
        p_im   = s_re_x * sn_x + s_im_x * c_x;
        q_re   = (p_re + RND) >>> (TW - 2);
        q_im   = (p_im + RND) >>> (TW - 2);
        sat_re = (q_re > SAT_MAX) ? SAT_MAX[ACCW-1:0] :
                 (q_re < SAT_MIN) ? SAT_MIN[ACCW-1:0] : q_re[ACCW-1:0];
        sat_im = (q_im > SAT_MAX) ? SAT_MAX[ACCW-1:0] :
                 (q_im < SAT_MIN) ? SAT_MIN[ACCW-1:0] : q_im[ACCW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst && state == S_COMB) begin
            dly_re[wr_ptr] <= x_re;
            dly_im[wr_ptr] <= x_im;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_bin    <= '0;
            out_re     <= '0;
            out_im     <= '0;
            out_primed <= 1'b0;
            fill       <= '0;
            wr_ptr     <= '0;
            cur_bin    <= '0;
            x_re       <= '0;
            x_im       <= '0;
            diff_re    <= '0;
            diff_im    <= '0;
            for (int i = 0; i < NBINS; i++) begin
                acc_re[i] <= '0;
                acc_im[i] <= '0;
                tw_c[i]   <= TW_ONE;
                tw_s[i]   <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tw_we && tw_addr_ok) begin
                        tw_c[tw_addr] <= tw_cos;
                        tw_s[tw_addr] <= tw_sin;
                    end
                    if (in_valid) begin
                        x_re     <= in_re;
                        x_im     <= in_im;
                        in_ready <= 1'b0;
                        state    <= S_COMB;
                    end
                end
                S_COMB: begin
                    diff_re <= {x_re[DW-1], x_re} - {old_re[DW-1], old_re};
                    diff_im <= {x_im[DW-1], x_im} - {old_im[DW-1], old_im};
                    wr_ptr  <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTRW'(1);
                    if (fill != FILL_N)
                        fill <= fill + FW'(1);
                    if (fill >= FILL_N - FW'(1))
                        out_primed <= 1'b1;
                    cur_bin <= '0;
                    state   <= S_BIN;
                end
                S_BIN: begin
                    acc_re[cur_bin] <= sat_re;
                    acc_im[cur_bin] <= sat_im;
                    out_valid       <= 1'b1;
                    out_bin         <= cur_bin;
                    out_re          <= sat_re;
                    out_im          <= sat_im;
                    if (cur_bin == LAST_BIN) begin
                        in_ready <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        cur_bin <= cur_bin + BW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rdft_bin_engine.sv
// Bench for rdft_bin_engine: directed DFT cases plus random traffic against a
// cycle-level arithmetic reference model of the sliding DFT.
module tb_rdft_bin_engine;
    localparam int DW    = 16;
    localparam int N     = 8;
    localparam int NBINS = 3;
    localparam int TW    = 18;
    localparam int ACCW  = DW + $clog2(N) + 2;
    localparam int BW    = 2;
    localparam longint SMAX = (64'sd1 <<< (ACCW - 1)) - 1;
    localparam longint SMIN = -(64'sd1 <<< (ACCW - 1));

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, tw_we, out_valid, out_primed;
    logic signed [DW-1:0]   in_re, in_im;
    logic [BW-1:0]          tw_addr, out_bin;
    logic signed [TW-1:0]   tw_cos, tw_sin;
    logic signed [ACCW-1:0] out_re, out_im;

    rdft_bin_engine #(.DW(DW), .N(N), .NBINS(NBINS), .TW(TW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .tw_we(tw_we), .tw_addr(tw_addr),
        .tw_cos(tw_cos), .tw_sin(tw_sin), .out_valid(out_valid), .out_bin(out_bin),
        .out_re(out_re), .out_im(out_im), .out_primed(out_primed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     due;
        int     bin;
        longint re;
        longint im;
    } exp_t;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     busy, prim_cyc, obs_cnt;
    bit     prim_pend, m_primed, ev;
    longint m_re [NBINS];
    longint m_im [NBINS];
    int     mc [NBINS];
    int     ms [NBINS];
    int     hist_re[$];
    int     hist_im[$];
    exp_t   expq[$];
    int     e_bin;
    longint e_re, e_im;
    longint obs_re [4];
    longint obs_im [4];

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic longint rnd_sat(longint p);
        longint r;
        r = (p + (64'sd1 <<< (TW - 3))) >>> (TW - 2);
        if (r > SMAX) r = SMAX;
        if (r < SMIN) r = SMIN;
        return r;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NBINS; k++) begin
            m_re[k] = 0; m_im[k] = 0; mc[k] = 1 << (TW - 2); ms[k] = 0;
        end
        hist_re.delete(); hist_im.delete(); expq.delete();
        busy = 0; m_primed = 0; prim_pend = 0;
        e_bin = 0; e_re = 0; e_im = 0;
    endfunction

    // S_k = W_k * (S_k + x[n] - x[n-N]) with x[n-N] = 0 before the window fills.
    function automatic void model_accept(int xr, int xi);
        int n;
        longint dr, di, sr, si;
        exp_t e;
        n  = hist_re.size();
        dr = xr - ((n >= N) ? hist_re[n-N] : 0);
        di = xi - ((n >= N) ? hist_im[n-N] : 0);
        hist_re.push_back(xr);
        hist_im.push_back(xi);
        if (hist_re.size() == N) begin
            prim_pend = 1; prim_cyc = cyc + 1;
        end
        busy = NBINS + 1;
        for (int k = 0; k < NBINS; k++) begin
            sr = m_re[k] + dr;
            si = m_im[k] + di;
            m_re[k] = rnd_sat(sr * mc[k] - si * ms[k]);
            m_im[k] = rnd_sat(sr * ms[k] + si * mc[k]);
            e.due = cyc + 2 + k; e.bin = k; e.re = m_re[k]; e.im = m_im[k];
            expq.push_back(e);
        end
    endfunction

    task automatic step();
        bit acc, twv;
        int xr, xi, ta, tc, ts, b;
        acc = (in_valid === 1'b1) && busy == 0 && !rst;
        twv = (tw_we === 1'b1) && busy == 0 && !rst && tw_addr < 2'd3;
        xr = in_re; xi = in_im; ta = tw_addr; tc = tw_cos; ts = tw_sin;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            if (busy > 0) busy--;
            if (prim_pend && cyc == prim_cyc) begin m_primed = 1; prim_pend = 0; end
            if (twv) begin mc[ta] = tc; ms[ta] = ts; end
            if (acc) model_accept(xr, xi);
        end
        ev = 0;
        if (expq.size() > 0 && expq[0].due == cyc) begin
            ev = 1; e_bin = expq[0].bin; e_re = expq[0].re; e_im = expq[0].im;
            void'(expq.pop_front());
        end
        chk("in_ready", in_ready, busy == 0);
        chk("out_valid", out_valid, ev);
        chk("out_primed", out_primed, m_primed);
        chk("out_bin", out_bin, e_bin);
        chk("out_re", out_re, e_re);
        chk("out_im", out_im, e_im);
        if (out_valid === 1'b1) begin
            obs_cnt++;
            b = out_bin;
            if (b >= 0 && b < 4) begin obs_re[b] = out_re; obs_im[b] = out_im; end
        end
    endtask

    task automatic send(input int re, input int im);
        int n = 0;
        in_valid = 1'b1; in_re = 16'(re); in_im = 16'(im);
        while (busy != 0 && n < 16) begin step(); n++; end
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_wait(input int re, input int im);
        send(re, im);
        repeat (NBINS + 1) step();
    endtask

    task automatic tw_write(input int a, input int c, input int s);
        tw_we = 1'b1; tw_addr = 2'(a); tw_cos = 18'(c); tw_sin = 18'(s);
        step();
        tw_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; step();
        rst = 1'b0; step();
    endtask

    initial begin
        int c0;
        longint mn;
        bit will;
        rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0;
        tw_we = 1'b0; tw_addr = '0; tw_cos = '0; tw_sin = '0;
        obs_cnt = 0;
        for (int i = 0; i < 4; i++) begin obs_re[i] = 0; obs_im[i] = 0; end
        model_reset();
        step(); step();
        rst = 1'b0; step();

        // DC into identity bins
        for (int i = 1; i <= 12; i++) begin
            send_wait(1000, 0);
            if (i == 1) chk("dc_b0_first", obs_re[0], 1000);
            if (i == 7) chk("dc_unprimed7", out_primed, 0);
            if (i == 8) begin
                chk("dc_b0_full", obs_re[0], 8000);
                chk("dc_primed8", out_primed, 1);
            end
            if (i == 12) chk("dc_b0_steady", obs_re[0], 8000);
        end

        // DC with bin2 rotating by j
        do_reset();
        tw_write(2, 0, 65536);
        for (int i = 1; i <= 9; i++) begin
            send_wait(1000, 0);
            if (i == 1) begin
                chk("dcj_b2_re1", obs_re[2], 0);
                chk("dcj_b2_im1", obs_im[2], 1000);
            end
            if (i >= 8) begin
                chk("dcj_b2_re_zero", obs_re[2], 0);
                chk("dcj_b2_im_zero", obs_im[2], 0);
            end
        end

        // twiddle write while busy is ignored; in idle it takes effect next sample
        send(1000, 0);
        tw_we = 1'b1; tw_addr = 2'd0; tw_cos = '0; tw_sin = '0;
        repeat (NBINS + 1) step();
        tw_we = 1'b0;
        send_wait(1000, 0);
        chk("tw_busy_ignored", obs_re[0], 8000);
        tw_write(0, 0, 65536);
        send_wait(1000, 0);
        chk("tw_idle_re", obs_re[0], 0);
        chk("tw_idle_im", obs_im[0], 8000);
        tw_write(3, 12345, 777);
        send_wait(1000, 0);
        chk("tw_addr3_b2", obs_re[2], 0);

        // impulse into bin2 with W=j
        do_reset();
        tw_write(2, 0, 65536);
        send_wait(1000, 0);
        chk("imp_b2_im0", obs_im[2], 1000);
        for (int i = 1; i <= 8; i++) begin
            send_wait(0, 0);
            if (i == 1) chk("imp_b2_re1", obs_re[2], -1000);
            if (i == 8) begin
                chk("imp_b2_re8", obs_re[2], 0);
                chk("imp_b2_im8", obs_im[2], 0);
            end
        end

        // in_valid held high: one sample every NBINS+2 cycles
        do_reset();
        c0 = obs_cnt;
        in_valid = 1'b1; in_re = 16'($urandom); in_im = 16'($urandom);
        for (int i = 0; i < 15; i++) begin
            will = (busy == 0);
            step();
            if (will) begin in_re = 16'($urandom); in_im = 16'($urandom); end
        end
        in_valid = 1'b0;
        chk("hold_pulses", obs_cnt - c0, 9);
        repeat (4) step();

        // saturation
        do_reset();
        tw_write(0, 131071, 131071);
        mn = 0;
        for (int i = 0; i < 10; i++) begin
            send_wait(32767, 0);
            if (obs_re[0] < mn) mn = obs_re[0];
        end
        chk("sat_min_re", mn, SMIN);

        // random traffic, twiddle writes (incl. bad address / while busy), rare resets
        do_reset();
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_re    = 16'($urandom);
            in_im    = 16'($urandom);
            tw_we    = ($urandom_range(0, 3) == 0);
            tw_addr  = 2'($urandom_range(0, 3));
            tw_cos   = 18'(int'($urandom_range(0, 131072)) - 65536);
            tw_sin   = 18'(int'($urandom_range(0, 131072)) - 65536);
            rst      = ($urandom_range(0, 127) == 0);
            step();
        end
        in_valid = 1'b0; tw_we = 1'b0; rst = 1'b0;
        repeat (6) step();

        // reset during BIN(1) abandons the pass
        do_reset();
        send(500, -300);
        step(); step();
        c0 = obs_cnt;
        rst = 1'b1; step();
        rst = 1'b0;
        repeat (6) step();
        chk("midrst_no_out", obs_cnt - c0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
